npu_loop_seq: RTL and testbench

// - Consumes the arrival values (arv_*) from the NPU control-parameter block and runs the conv loop nest.
// - Counters step through it; one step is issued per valid/ready handshake with the NPU datapath.
// - Generates index, first/last flags and per-column clock-enable vector; sits between the ctrl-param block and the array.

---
 rtl/npu_loop_seq_if.sv | 44 ++++
 rtl/npu_loop_seq.sv | 179 +++++++++++++++++
 tb/tb_npu_loop_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/npu_loop_seq_if.sv
// Handshake/bus bundle between the ctrl-param block, the loop sequencer and the NPU datapath.
interface npu_loop_seq_if #(
    parameter int unsigned W      = 64,
    parameter int unsigned K      = 3,
    parameter int unsigned CLOG2T = 8,
    parameter int unsigned CLOG2B = 8,
    parameter int unsigned CLOG2C = 8
);
    localparam int unsigned CLOG2W = $clog2(W);
    localparam int unsigned CLOG2K = $clog2(K);

    logic              start;
    logic [CLOG2W-1:0] arv_npu;
    logic [CLOG2K-1:0] arv_ksize;
    logic [CLOG2W-1:0] arv_ckgate;
    logic [CLOG2T-1:0] arv_tile;
    logic [CLOG2B-1:0] arv_ifmaps;
    logic [CLOG2C-1:0] arv_ofmaps;
    logic              ready;
    logic              valid;
    logic [CLOG2K-1:0] cnt_k;
    logic [CLOG2W-1:0] cnt_npu;
    logic [CLOG2T-1:0] cnt_tile;
    logic [CLOG2B-1:0] cnt_ifm;
    logic [CLOG2C-1:0] cnt_ofm;
    logic              first_ifm;
    logic              last_ifm;
    logic [W-1:0]      ck_en;
    logic              busy;
    logic              done;
    logic [31:0]       stall_cnt;

    modport master (
        output start, arv_npu, arv_ksize, arv_ckgate, arv_tile, arv_ifmaps, arv_ofmaps, ready,
        input  valid, cnt_k, cnt_npu, cnt_tile, cnt_ifm, cnt_ofm, first_ifm, last_ifm,
               ck_en, busy, done, stall_cnt
    );

    modport slave (
        input  start, arv_npu, arv_ksize, arv_ckgate, arv_tile, arv_ifmaps, arv_ofmaps, ready,
        output valid, cnt_k, cnt_npu, cnt_tile, cnt_ifm, cnt_ofm, first_ifm, last_ifm,
               ck_en, busy, done, stall_cnt
    );
endinterface

// File: rtl/npu_loop_seq.sv
// Conv loop-nest sequencer: walks k/npu/tile/ifm/ofm one step per valid/ready handshake.
// Optional stall counter enabled by defining NPU_SEQ_PERF_EN.
module npu_loop_seq #(
    parameter int unsigned W      = 64,
    parameter int unsigned K      = 3,
    parameter int unsigned CLOG2T = 8,
    parameter int unsigned CLOG2B = 8,
    parameter int unsigned CLOG2C = 8
) (
    input logic         clk,
    input logic         rst,
    npu_loop_seq_if.slave bus
);
    localparam int unsigned CLOG2W = $clog2(W);
    localparam int unsigned CLOG2K = $clog2(K);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    state_e            state_q;
    logic [CLOG2K-1:0] k_q, k_d, sk_q;
    logic [CLOG2W-1:0] npu_q, npu_d, snpu_q;
    logic [CLOG2T-1:0] tile_q, tile_d, stile_q;
    logic [CLOG2B-1:0] ifm_q, ifm_d, sifm_q;
    logic [CLOG2C-1:0] ofm_q, ofm_d, sofm_q;
    logic              valid_q, busy_q, done_q, first_q, last_q;
    logic [W-1:0]      ck_en_q, ck_en_d;
    logic              step_c, all_last_c, first_d, last_d;

    // Column enable decode from the live ckgate input; captured on start and again in LOAD.
    always_comb begin
        ck_en_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            ck_en_d[i] = (i <= 32'(bus.arv_ckgate));
        end
    end

    // Next indices: innermost k wraps at its latched limit and carries outward.
    always_comb begin
        step_c     = valid_q && bus.ready;
        k_d        = k_q;
        npu_d      = npu_q;
        tile_d     = tile_q;
        ifm_d      = ifm_q;
        ofm_d      = ofm_q;
        all_last_c = (k_q == sk_q) && (npu_q == snpu_q) && (tile_q == stile_q) &&
                     (ifm_q == sifm_q) && (ofm_q == sofm_q);
        if (step_c) begin
            if (k_q != sk_q) begin
                k_d = CLOG2K'(k_q + 1'b1);
            end else begin
                k_d = '0;
                if (npu_q != snpu_q) begin
                    npu_d = CLOG2W'(npu_q + 1'b1);
                end else begin
                    npu_d = '0;
                    if (tile_q != stile_q) begin
                        tile_d = CLOG2T'(tile_q + 1'b1);
                    end else begin
                        tile_d = '0;
                        if (ifm_q != sifm_q) begin
                            ifm_d = CLOG2B'(ifm_q + 1'b1);
                        end else begin
                            ifm_d = '0;
                            ofm_d = (ofm_q != sofm_q) ? CLOG2C'(ofm_q + 1'b1) : '0;
                        end
                    end
                end
            end
        end
        first_d = (ifm_d == '0) && (k_d == '0);
        last_d  = (ifm_d == sifm_q) && (k_d == sk_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            npu_q   <= '0;
            tile_q  <= '0;
            ifm_q   <= '0;
            ofm_q   <= '0;
            sk_q    <= '0;
            snpu_q  <= '0;
            stile_q <= '0;
            sifm_q  <= '0;
            sofm_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ck_en_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        ck_en_q <= ck_en_d;
                    end
                end
                S_LOAD: begin
                    sk_q    <= bus.arv_ksize;
                    snpu_q  <= bus.arv_npu;
                    stile_q <= bus.arv_tile;
                    sifm_q  <= bus.arv_ifmaps;
                    sofm_q  <= bus.arv_ofmaps;
                    k_q     <= '0;
                    npu_q   <= '0;
                    tile_q  <= '0;
                    ifm_q   <= '0;
                    ofm_q   <= '0;
                    first_q <= 1'b1;
                    last_q  <= (bus.arv_ifmaps == '0) && (bus.arv_ksize == '0);
                    valid_q <= 1'b1;
                    ck_en_q <= ck_en_d;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (step_c) begin
                        k_q    <= k_d;
                        npu_q  <= npu_d;
                        tile_q <= tile_d;
                        ifm_q  <= ifm_d;
                        ofm_q  <= ofm_d;
                        if (all_last_c) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            first_q <= first_d;
                            last_q  <= last_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ck_en_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef NPU_SEQ_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of RUN cycles where the datapath withheld ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == S_LOAD) begin
            stall_q <= '0;
        end else if (valid_q && !bus.ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif

    assign bus.valid     = valid_q;
    assign bus.cnt_k     = k_q;
    assign bus.cnt_npu   = npu_q;
    assign bus.cnt_tile  = tile_q;
    assign bus.cnt_ifm   = ifm_q;
    assign bus.cnt_ofm   = ofm_q;
    assign bus.first_ifm = first_q;
    assign bus.last_ifm  = last_q;
    assign bus.ck_en     = ck_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_npu_loop_seq.sv
// Scoreboard bench for npu_loop_seq: driver pushes expected steps/done cycles, negedge monitor checks.
module tb_npu_loop_seq;
    localparam int unsigned W      = 64;
    localparam int unsigned K      = 3;
    localparam int unsigned CLOG2T = 8;
    localparam int unsigned CLOG2B = 8;
    localparam int unsigned CLOG2C = 8;

    typedef struct {
        int          k, npu, tile, ifm, ofm;
        bit          first, last;
        logic [W-1:0] ck;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    step_t exp_q[$];
    int    exp_done[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npu_loop_seq_if #(.W(W), .K(K), .CLOG2T(CLOG2T), .CLOG2B(CLOG2B), .CLOG2C(CLOG2C)) bus ();

    npu_loop_seq #(.W(W), .K(K), .CLOG2T(CLOG2T), .CLOG2B(CLOG2B), .CLOG2C(CLOG2C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference walk of the loop nest straight from the nesting rules.
    task automatic push_pass(input int ak, input int an, input int at, input int ai, input int ao,
                             input int ag);
        step_t s;
        logic [W-1:0] ck;
        for (int i = 0; i < W; i++) ck[i] = (i <= ag);
        for (int o = 0; o <= ao; o++)
            for (int f = 0; f <= ai; f++)
                for (int t = 0; t <= at; t++)
                    for (int n = 0; n <= an; n++)
                        for (int k = 0; k <= ak; k++) begin
                            s.k = k; s.npu = n; s.tile = t; s.ifm = f; s.ofm = o;
                            s.first = (f == 0) && (k == 0);
                            s.last  = (f == ai) && (k == ak);
                            s.ck    = ck;
                            exp_q.push_back(s);
                        end
    endtask

    task automatic set_arv(input int ak, input int an, input int at, input int ai, input int ao,
                           input int ag);
        bus.arv_ksize  = 2'(ak);
        bus.arv_npu    = 6'(an);
        bus.arv_tile   = 8'(at);
        bus.arv_ifmaps = 8'(ai);
        bus.arv_ofmaps = 8'(ao);
        bus.arv_ckgate = 6'(ag);
    endtask

    // mode 0: ready always 1; 1: random ready + input noise; 2: ready low at start+3..start+5.
    task automatic run_pass(input int ak, input int an, input int at, input int ai, input int ao,
                            input int ag, input int mode, input bit start_in_done);
        int s, total, steps, stalls, exp_stall;
        bit r;
        set_arv(ak, an, at, ai, ao, ag);
        push_pass(ak, an, at, ai, ao, ag);
        total = (ak + 1) * (an + 1) * (at + 1) * (ai + 1) * (ao + 1);
        s = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ready = 1'($urandom);
        tick();
        steps = 0;
        stalls = 0;
        while (steps < total) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = ($urandom % 4) != 0;
            else r = !((cyc >= s + 3) && (cyc <= s + 5));
            bus.ready = r;
            if (mode == 1) begin
                set_arv(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                        int'($urandom), int'($urandom));
                bus.start = ($urandom % 6) == 0;
            end
            if (r) steps++;
            else stalls++;
            tick();
        end
        exp_done.push_back(s + 2 + total + stalls);
        bus.ready = 1'($urandom);
        bus.start = start_in_done;
        tick();
        bus.start = 1'b0;
`ifdef NPU_SEQ_PERF_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        chk("idle_busy", bus.busy, 0);
        chk("idle_valid", bus.valid, 0);
        chk("idle_ck_en", bus.ck_en, 0);
        chk("stall_cnt", bus.stall_cnt, exp_stall);
        chk("done_pending", exp_done.size(), 0);
        chk("steps_pending", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_first"}, bus.first_ifm, 0);
        chk({tag, "_last"}, bus.last_ifm, 0);
        chk({tag, "_ck_en"}, bus.ck_en, 0);
        chk({tag, "_cnt"}, {bus.cnt_k, bus.cnt_npu, bus.cnt_tile, bus.cnt_ifm, bus.cnt_ofm}, 0);
        chk({tag, "_stall"}, bus.stall_cnt, 0);
    endtask

    // Monitor: compares presented step against scoreboard head; pops on handshake.
    always @(negedge clk) begin
        step_t e;
        if (!rst) begin
            if (bus.valid) begin
                chk("sb_has_step", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("cnt_k", bus.cnt_k, e.k);
                    chk("cnt_npu", bus.cnt_npu, e.npu);
                    chk("cnt_tile", bus.cnt_tile, e.tile);
                    chk("cnt_ifm", bus.cnt_ifm, e.ifm);
                    chk("cnt_ofm", bus.cnt_ofm, e.ofm);
                    chk("first_ifm", bus.first_ifm, e.first);
                    chk("last_ifm", bus.last_ifm, e.last);
                    chk("ck_en", bus.ck_en, e.ck);
                    chk("run_busy", bus.busy, 1);
                    if (bus.ready) void'(exp_q.pop_front());
                end
            end
            if (bus.done) begin
                chk("done_valid", bus.valid, 0);
                chk("sb_has_done", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ak, an, at, ai, ao;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        set_arv(0, 0, 0, 0, 0, 0);
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_pass(0, 0, 0, 0, 0, 0, 0, 1'b0);
        run_pass(2, 1, 0, 0, 0, 61, 0, 1'b1);
        run_pass(2, 0, 0, 1, 0, 1, 0, 1'b0);
        run_pass(2, 0, 0, 1, 0, 63, 2, 1'b1);

        // Asynchronous reset in the middle of a pass, then a clean full pass.
        set_arv(2, 1, 0, 0, 0, 5);
        push_pass(2, 1, 0, 0, 0, 5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_pass(2, 1, 0, 0, 0, 5, 0, 1'b0);

        for (int p = 0; p < 15; p++) begin
            ak = $urandom % 4;
            an = $urandom % 4;
            at = $urandom % 3;
            ai = $urandom % 3;
            ao = $urandom % 3;
            run_pass(ak, an, at, ai, ao, int'($urandom % 64), 1, 1'($urandom));
        end

        tick();
        chk("final_steps", exp_q.size(), 0);
        chk("final_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
